// File: rtl/isp_gamma_lut_loader_if.sv
// Entry stream and gamma LUT configuration port bundle for isp_gamma_lut_loader.
// master = loader side, slave = host stream source plus the three LUT RAMs.
interface isp_gamma_lut_loader_if #(
   parameter int BITS = 8
);
   logic            s_valid;
   logic            s_ready;
   logic [BITS-1:0] s_data;

   logic            cfg_table_r_wen;
   logic            cfg_table_g_wen;
   logic            cfg_table_b_wen;
   logic            cfg_table_r_ren;
   logic            cfg_table_g_ren;
   logic            cfg_table_b_ren;
   logic [BITS-1:0] cfg_table_r_addr;
   logic [BITS-1:0] cfg_table_g_addr;
   logic [BITS-1:0] cfg_table_b_addr;
   logic [BITS-1:0] cfg_table_r_wdata;
   logic [BITS-1:0] cfg_table_g_wdata;
   logic [BITS-1:0] cfg_table_b_wdata;
   logic [BITS-1:0] cfg_table_r_rdata;
   logic [BITS-1:0] cfg_table_g_rdata;
   logic [BITS-1:0] cfg_table_b_rdata;

   modport master (
      input  s_valid, s_data,
      input  cfg_table_r_rdata, cfg_table_g_rdata, cfg_table_b_rdata,
      output s_ready,
      output cfg_table_r_wen, cfg_table_g_wen, cfg_table_b_wen,
      output cfg_table_r_ren, cfg_table_g_ren, cfg_table_b_ren,
      output cfg_table_r_addr, cfg_table_g_addr, cfg_table_b_addr,
      output cfg_table_r_wdata, cfg_table_g_wdata, cfg_table_b_wdata
   );

   modport slave (
      output s_valid, s_data,
      output cfg_table_r_rdata, cfg_table_g_rdata, cfg_table_b_rdata,
      input  s_ready,
      input  cfg_table_r_wen, cfg_table_g_wen, cfg_table_b_wen,
      input  cfg_table_r_ren, cfg_table_g_ren, cfg_table_b_ren,
      input  cfg_table_r_addr, cfg_table_g_addr, cfg_table_b_addr,
      input  cfg_table_r_wdata, cfg_table_g_wdata, cfg_table_b_wdata
   );
endinterface

// File: rtl/isp_gamma_lut_loader.sv
// Loads R/G/B gamma LUTs from an entry stream, starting on the next in_vsync rising edge.
// Define GAMMA_LUT_VERIFY_EN to add a read-back pass that compares per-channel sums.
module isp_gamma_lut_loader #(
   parameter int BITS = 8
) (
   input  logic                  pclk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_vsync,
   isp_gamma_lut_loader_if.master lut,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam logic [BITS-1:0] CNT_LAST = {BITS{1'b1}};
   localparam logic [BITS-1:0] CNT_ONE  = {{(BITS-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_WRITE  = 3'd2,
      S_VERIFY = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic            vsync_q;
   logic [BITS-1:0] cnt_q, cnt_d;
   logic [1:0]      ch_q, ch_d;
   logic [BITS-1:0] addr_q, addr_d;
   logic [BITS-1:0] wdata_q, wdata_d;
   logic [2:0]      wen_q, wen_d;
   logic            s_ready_q, s_ready_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            beat_s;
   logic            chan_end_s;

`ifdef GAMMA_LUT_VERIFY_EN
   logic [2:0]        ren_q, ren_d;
   logic [2:0]        rd_v_q, rd_v_d;
   logic              rd_last_q, rd_last_d;
   logic              issue_done_q, issue_done_d;
   logic              err_q, err_d;
   logic [2*BITS-1:0] wsum_q [3];
   logic [2*BITS-1:0] wsum_d [3];
   logic [2*BITS-1:0] rsum_q, rsum_d;
   logic [2*BITS-1:0] rd_sum_s;
   logic [2*BITS-1:0] wsum_sel_s;
   logic [BITS-1:0]   rdata_s;
`endif

   assign beat_s     = lut.s_valid & s_ready_q;
   assign chan_end_s = (cnt_q == CNT_LAST);

   // State and output registers.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         vsync_q   <= 1'b0;
         cnt_q     <= {BITS{1'b0}};
         ch_q      <= 2'd0;
         addr_q    <= {BITS{1'b0}};
         wdata_q   <= {BITS{1'b0}};
         wen_q     <= 3'b000;
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef GAMMA_LUT_VERIFY_EN
         ren_q        <= 3'b000;
         rd_v_q       <= 3'b000;
         rd_last_q    <= 1'b0;
         issue_done_q <= 1'b0;
         err_q        <= 1'b0;
         rsum_q       <= {(2*BITS){1'b0}};
         for (int i = 0; i < 3; i++) wsum_q[i] <= {(2*BITS){1'b0}};
`endif
      end else begin
         state_q   <= state_d;
         vsync_q   <= in_vsync;
         cnt_q     <= cnt_d;
         ch_q      <= ch_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wen_q     <= wen_d;
         s_ready_q <= s_ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef GAMMA_LUT_VERIFY_EN
         ren_q        <= ren_d;
         rd_v_q       <= rd_v_d;
         rd_last_q    <= rd_last_d;
         issue_done_q <= issue_done_d;
         err_q        <= err_d;
         rsum_q       <= rsum_d;
         for (int i = 0; i < 3; i++) wsum_q[i] <= wsum_d[i];
`endif
      end
   end

`ifdef GAMMA_LUT_VERIFY_EN
   // Read data arriving this cycle belongs to the channel strobed one cycle earlier.
   always_comb begin
      rdata_s    = {BITS{1'b0}};
      wsum_sel_s = wsum_q[2];
      if (rd_v_q[0]) begin
         rdata_s    = lut.cfg_table_r_rdata;
         wsum_sel_s = wsum_q[0];
      end else if (rd_v_q[1]) begin
         rdata_s    = lut.cfg_table_g_rdata;
         wsum_sel_s = wsum_q[1];
      end else if (rd_v_q[2]) begin
         rdata_s = lut.cfg_table_b_rdata;
      end else begin
         rdata_s = {BITS{1'b0}};
      end
      rd_sum_s = rsum_q + {{BITS{1'b0}}, rdata_s};
   end
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ch_d    = ch_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wen_d   = 3'b000;
`ifdef GAMMA_LUT_VERIFY_EN
      ren_d        = 3'b000;
      rd_v_d       = ren_q;
      rd_last_d    = (|ren_q) && (addr_q == CNT_LAST);
      issue_done_d = issue_done_q;
      err_d        = err_q;
      rsum_d       = rsum_q;
      wsum_d       = wsum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ARM;
               cnt_d   = {BITS{1'b0}};
               ch_d    = 2'd0;
`ifdef GAMMA_LUT_VERIFY_EN
               err_d        = 1'b0;
               rsum_d       = {(2*BITS){1'b0}};
               issue_done_d = 1'b0;
               for (int i = 0; i < 3; i++) wsum_d[i] = {(2*BITS){1'b0}};
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ARM: begin
            if (in_vsync && !vsync_q) state_d = S_WRITE;
            else                      state_d = S_ARM;
         end
         S_WRITE: begin
            if (beat_s) begin
               addr_d  = cnt_q;
               wdata_d = lut.s_data;
               wen_d   = 3'b001 << ch_q;
               cnt_d   = cnt_q + CNT_ONE;
`ifdef GAMMA_LUT_VERIFY_EN
               for (int i = 0; i < 3; i++) begin
                  if (ch_q == 2'(i)) wsum_d[i] = wsum_q[i] + {{BITS{1'b0}}, lut.s_data};
                  else               wsum_d[i] = wsum_q[i];
               end
`endif
               if (chan_end_s && ch_q == 2'd2) begin
                  ch_d = 2'd0;
`ifdef GAMMA_LUT_VERIFY_EN
                  state_d = S_VERIFY;
`else
                  state_d = S_DONE;
`endif
               end else if (chan_end_s) begin
                  ch_d = ch_q + 2'd1;
               end else begin
                  ch_d = ch_q;
               end
            end else begin
               state_d = S_WRITE;
            end
         end
         S_VERIFY: begin
`ifdef GAMMA_LUT_VERIFY_EN
            if (!issue_done_q) begin
               ren_d  = 3'b001 << ch_q;
               addr_d = cnt_q;
               cnt_d  = cnt_q + CNT_ONE;
               if (chan_end_s && ch_q == 2'd2) begin
                  ch_d         = 2'd0;
                  issue_done_d = 1'b1;
               end else if (chan_end_s) begin
                  ch_d = ch_q + 2'd1;
               end else begin
                  ch_d = ch_q;
               end
            end else begin
               ren_d = 3'b000;
            end
            // Per-channel sum closes on the last address; the B close ends the pass.
            if ((|rd_v_q) && rd_last_q) begin
               rsum_d  = {(2*BITS){1'b0}};
               err_d   = err_q | (rd_sum_s != wsum_sel_s);
               state_d = rd_v_q[2] ? S_DONE : S_VERIFY;
            end else if (|rd_v_q) begin
               rsum_d = rd_sum_s;
            end else begin
               rsum_d = rsum_q;
            end
`else
            state_d = S_IDLE;
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      s_ready_d = (state_d == S_WRITE);
      busy_d    = (state_d inside {S_ARM, S_WRITE, S_VERIFY});
      done_d    = (state_d == S_DONE);
   end

   assign lut.s_ready           = s_ready_q;
   assign lut.cfg_table_r_wen   = wen_q[0];
   assign lut.cfg_table_g_wen   = wen_q[1];
   assign lut.cfg_table_b_wen   = wen_q[2];
   assign lut.cfg_table_r_addr  = addr_q;
   assign lut.cfg_table_g_addr  = addr_q;
   assign lut.cfg_table_b_addr  = addr_q;
   assign lut.cfg_table_r_wdata = wdata_q;
   assign lut.cfg_table_g_wdata = wdata_q;
   assign lut.cfg_table_b_wdata = wdata_q;
   assign busy                  = busy_q;
   assign done                  = done_q;
`ifdef GAMMA_LUT_VERIFY_EN
   assign lut.cfg_table_r_ren = ren_q[0];
   assign lut.cfg_table_g_ren = ren_q[1];
   assign lut.cfg_table_b_ren = ren_q[2];
   assign err                 = err_q;
`else
   assign lut.cfg_table_r_ren = 1'b0;
   assign lut.cfg_table_g_ren = 1'b0;
   assign lut.cfg_table_b_ren = 1'b0;
   assign err                 = 1'b0;
`endif
endmodule

// File: tb/tb_isp_gamma_lut_loader.sv
// Directed bench for isp_gamma_lut_loader with BITS=8 and model LUT RAMs.
module tb_isp_gamma_lut_loader;
   localparam int BITS  = 8;
   localparam int N     = 256;
   localparam int TOTAL = 3 * N;
`ifdef GAMMA_LUT_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic pclk = 1'b0;
   logic rst, start, in_vsync;
   logic busy, done, err;
   always #5 pclk = ~pclk;

   isp_gamma_lut_loader_if #(.BITS(BITS)) lif ();

   isp_gamma_lut_loader #(.BITS(BITS)) dut (
      .pclk(pclk), .rst(rst), .start(start), .in_vsync(in_vsync),
      .lut(lif), .busy(busy), .done(done), .err(err)
   );

   int checks = 0;
   int failures = 0;
   logic mon_clr, fault;
   logic [7:0] ram_r [N];
   logic [7:0] ram_g [N];
   logic [7:0] ram_b [N];
   int wen_cnt [3];
   int ren_cnt [3];
   int seq_err, gap_err, strobe_err, done_cnt;
   logic acc_prev;
   logic [2:0] wen_v, ren_v;
   assign wen_v = {lif.cfg_table_b_wen, lif.cfg_table_g_wen, lif.cfg_table_r_wen};
   assign ren_v = {lif.cfg_table_b_ren, lif.cfg_table_g_ren, lif.cfg_table_r_ren};

   // Model LUT RAMs plus strobe-order monitor; data of entry i is i & 0xFF, so wdata must equal addr.
   always @(posedge pclk) begin
      if (mon_clr) begin
         for (int i = 0; i < N; i++) begin
            ram_r[i] <= 8'hA5; ram_g[i] <= 8'hA5; ram_b[i] <= 8'hA5;
         end
         for (int c = 0; c < 3; c++) begin
            wen_cnt[c] <= 0; ren_cnt[c] <= 0;
         end
         seq_err <= 0; gap_err <= 0; strobe_err <= 0; done_cnt <= 0; acc_prev <= 1'b0;
      end else begin
         acc_prev <= lif.s_valid & lif.s_ready;
         if ((|wen_v) != acc_prev) gap_err <= gap_err + 1;
         if ($countones({wen_v, ren_v}) > 1) strobe_err <= strobe_err + 1;
         if (done) done_cnt <= done_cnt + 1;
         if (wen_v[0]) begin
            ram_r[lif.cfg_table_r_addr] <= lif.cfg_table_r_wdata;
            wen_cnt[0] <= wen_cnt[0] + 1;
            if (wen_cnt[1] != 0 || wen_cnt[2] != 0 || int'(lif.cfg_table_r_addr) != wen_cnt[0] ||
                lif.cfg_table_r_wdata != lif.cfg_table_r_addr) seq_err <= seq_err + 1;
         end
         if (wen_v[1]) begin
            ram_g[lif.cfg_table_g_addr] <= lif.cfg_table_g_wdata;
            wen_cnt[1] <= wen_cnt[1] + 1;
            if (wen_cnt[0] != N || wen_cnt[2] != 0 || int'(lif.cfg_table_g_addr) != wen_cnt[1] ||
                lif.cfg_table_g_wdata != lif.cfg_table_g_addr) seq_err <= seq_err + 1;
         end
         if (wen_v[2]) begin
            ram_b[lif.cfg_table_b_addr] <= lif.cfg_table_b_wdata;
            wen_cnt[2] <= wen_cnt[2] + 1;
            if (wen_cnt[0] != N || wen_cnt[1] != N || int'(lif.cfg_table_b_addr) != wen_cnt[2] ||
                lif.cfg_table_b_wdata != lif.cfg_table_b_addr) seq_err <= seq_err + 1;
         end
         if (ren_v[0]) begin
            lif.cfg_table_r_rdata <= ram_r[lif.cfg_table_r_addr];
            ren_cnt[0] <= ren_cnt[0] + 1;
         end
         if (ren_v[1]) begin
            lif.cfg_table_g_rdata <= (fault && lif.cfg_table_g_addr == 8'd17) ? 8'h00 : ram_g[lif.cfg_table_g_addr];
            ren_cnt[1] <= ren_cnt[1] + 1;
         end
         if (ren_v[2]) begin
            lif.cfg_table_b_rdata <= ram_b[lif.cfg_table_b_addr];
            ren_cnt[2] <= ren_cnt[2] + 1;
         end
      end
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic clear_monitor();
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
   endtask

   task automatic arm_load();
      start = 1'b1;
      tick();
      start = 1'b0;
      in_vsync = 1'b0;
      tick();
      in_vsync = 1'b1;
      tick();
   endtask

   // Returns one cycle after the last accepted beat; in_vsync toggles to show it is ignored.
   task automatic drive_load(input int nbeats, input int gap_pct, input int start_at, output int accepted);
      int cyc;
      bit v, acc;
      accepted = 0;
      cyc = 0;
      while (accepted < nbeats && cyc < 20 * TOTAL) begin
         v = (gap_pct == 0) || ($urandom_range(0, 99) >= gap_pct);
         lif.s_valid = v;
         lif.s_data  = 8'(accepted);
         start       = (accepted == start_at);
         in_vsync    = ((accepted / 37) % 2) == 1;
         acc = v && lif.s_ready;
         tick();
         if (acc) accepted++;
         cyc++;
      end
      lif.s_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 5000) begin
         tick();
         n++;
      end
   endtask

   function automatic int table_errs();
      int e = 0;
      for (int i = 0; i < N; i++) begin
         if (ram_r[i] !== 8'(i)) e++;
         if (ram_g[i] !== 8'(i)) e++;
         if (ram_b[i] !== 8'(i)) e++;
      end
      return e;
   endfunction

   task automatic test_reset();
      rst = 1'b1; mon_clr = 1'b1; fault = 1'b0; start = 1'b0; in_vsync = 1'b0;
      lif.s_valid = 1'b0; lif.s_data = 8'h00;
      tick();
      checks++;
      if ({busy, done, err, lif.s_ready} !== 4'b0000) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, err, lif.s_ready});
      end
      checks++;
      if ({wen_v, ren_v} !== 6'b000000) begin
         failures++; $display("FAIL reset_strobes got=%b exp=000000", {wen_v, ren_v});
      end
      checks++;
      if ({lif.cfg_table_r_addr, lif.cfg_table_g_addr, lif.cfg_table_b_addr,
           lif.cfg_table_r_wdata, lif.cfg_table_g_wdata, lif.cfg_table_b_wdata} !== 48'h0) begin
         failures++; $display("FAIL reset_addr_data got=%h exp=0", {lif.cfg_table_r_addr, lif.cfg_table_r_wdata});
      end
      tick();
      rst = 1'b0;
      tick();
      mon_clr = 1'b0;
      tick();
   endtask

   task automatic test_arm_wait();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({busy, lif.s_ready} !== 2'b10) begin
         failures++; $display("FAIL arm_entry busy/s_ready got=%b exp=10", {busy, lif.s_ready});
      end
      repeat (30) tick();
      checks++;
      if ({busy, lif.s_ready, done} !== 3'b100) begin
         failures++; $display("FAIL arm_hold busy/s_ready/done got=%b exp=100", {busy, lif.s_ready, done});
      end
   endtask

   task automatic test_full_load();
      int acc, n;
      in_vsync = 1'b1;
      checks++;
      if (lif.s_ready !== 1'b0) begin
         failures++; $display("FAIL full_edge_cycle s_ready got=%b exp=0", lif.s_ready);
      end
      tick();
      checks++;
      if (lif.s_ready !== 1'b1) begin
         failures++; $display("FAIL full_write_entry s_ready got=%b exp=1", lif.s_ready);
      end
      drive_load(TOTAL, 0, -1, acc);
      checks++;
      if (acc !== TOTAL) begin
         failures++; $display("FAIL full_accepts got=%0d exp=%0d", acc, TOTAL);
      end
      checks++;
      if ({done, busy, lif.s_ready, wen_v, lif.cfg_table_b_addr} !== {~VERIFY, VERIFY, 1'b0, 3'b100, 8'hFF}) begin
         failures++; $display("FAIL full_last_cycle done/busy/rdy/wen/addr got=%b exp=%b",
            {done, busy, lif.s_ready, wen_v, lif.cfg_table_b_addr}, {~VERIFY, VERIFY, 1'b0, 3'b100, 8'hFF});
      end
      wait_done(n);
      checks++;
      if (n !== (VERIFY ? 3 * N + 2 : 0)) begin
         failures++; $display("FAIL full_done_latency got=%0d exp=%0d", n, VERIFY ? 3 * N + 2 : 0);
      end
      tick();
      checks++;
      if ({done, busy} !== 2'b00) begin
         failures++; $display("FAIL full_after_done done/busy got=%b exp=00", {done, busy});
      end
      checks++;
      if (wen_cnt[0] !== N || wen_cnt[1] !== N || wen_cnt[2] !== N) begin
         failures++; $display("FAIL full_wen_counts got=%0d/%0d/%0d exp=256 each", wen_cnt[0], wen_cnt[1], wen_cnt[2]);
      end
      checks++;
      if ({seq_err, gap_err, strobe_err} !== {32'd0, 32'd0, 32'd0}) begin
         failures++; $display("FAIL full_sequence seq/gap/strobe got=%0d/%0d/%0d exp=0", seq_err, gap_err, strobe_err);
      end
      checks++;
      if (table_errs() !== 0 || done_cnt !== 1) begin
         failures++; $display("FAIL full_tables errs=%0d done_pulses=%0d exp=0/1", table_errs(), done_cnt);
      end
   endtask

   task automatic test_throttled();
      int acc, n;
      clear_monitor();
      arm_load();
      drive_load(TOTAL, 50, -1, acc);
      wait_done(n);
      tick();
      checks++;
      if (acc !== TOTAL || n !== (VERIFY ? 3 * N + 2 : 0)) begin
         failures++; $display("FAIL thr_accepts/latency got=%0d/%0d exp=%0d/%0d", acc, n, TOTAL, VERIFY ? 3 * N + 2 : 0);
      end
      checks++;
      if ({seq_err, gap_err, strobe_err} !== {32'd0, 32'd0, 32'd0}) begin
         failures++; $display("FAIL thr_sequence seq/gap/strobe got=%0d/%0d/%0d exp=0", seq_err, gap_err, strobe_err);
      end
      checks++;
      if (table_errs() !== 0 || wen_cnt[2] !== N) begin
         failures++; $display("FAIL thr_tables errs=%0d wen_b=%0d exp=0/256", table_errs(), wen_cnt[2]);
      end
   endtask

   task automatic test_boundary();
      int acc, n;
      clear_monitor();
      in_vsync = 1'b0;
      tick();
      start = 1'b1;
      in_vsync = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      checks++;
      if ({busy, lif.s_ready} !== 2'b10) begin
         failures++; $display("FAIL bnd_same_cycle_edge busy/s_ready got=%b exp=10", {busy, lif.s_ready});
      end
      in_vsync = 1'b0;
      tick();
      tick();
      in_vsync = 1'b1;
      tick();
      checks++;
      if (lif.s_ready !== 1'b1) begin
         failures++; $display("FAIL bnd_second_edge s_ready got=%b exp=1", lif.s_ready);
      end
      drive_load(TOTAL, 0, 100, acc);
      wait_done(n);
      repeat (4) tick();
      checks++;
      if (acc !== TOTAL || wen_cnt[0] + wen_cnt[1] + wen_cnt[2] !== TOTAL || done_cnt !== 1) begin
         failures++; $display("FAIL bnd_start_in_write acc=%0d wens=%0d done=%0d exp=768/768/1",
            acc, wen_cnt[0] + wen_cnt[1] + wen_cnt[2], done_cnt);
      end
      checks++;
      if (busy !== 1'b0 || table_errs() !== 0) begin
         failures++; $display("FAIL bnd_idle_after busy=%b errs=%0d exp=0/0", busy, table_errs());
      end
   endtask

   task automatic test_midload_reset();
      int acc, n;
      clear_monitor();
      arm_load();
      drive_load(300, 0, -1, acc);
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, err, lif.s_ready, wen_v, ren_v} !== 10'b0 || lif.cfg_table_g_addr !== 8'h00 ||
          lif.cfg_table_g_wdata !== 8'h00) begin
         failures++; $display("FAIL mid_reset_outputs got=%b/%h/%h exp=0", {busy, done, err, lif.s_ready, wen_v, ren_v},
            lif.cfg_table_g_addr, lif.cfg_table_g_wdata);
      end
      mon_clr = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      mon_clr = 1'b0;
      repeat (20) tick();
      checks++;
      if (done_cnt !== 0 || busy !== 1'b0) begin
         failures++; $display("FAIL mid_no_done done_pulses=%0d busy=%b exp=0/0", done_cnt, busy);
      end
      arm_load();
      drive_load(TOTAL, 0, -1, acc);
      wait_done(n);
      tick();
      checks++;
      if (table_errs() !== 0 || done_cnt !== 1 || seq_err !== 0) begin
         failures++; $display("FAIL mid_reload errs=%0d done=%0d seq=%0d exp=0/1/0", table_errs(), done_cnt, seq_err);
      end
   endtask

`ifdef GAMMA_LUT_VERIFY_EN
   task automatic test_verify();
      int acc, n;
      clear_monitor();
      arm_load();
      drive_load(TOTAL, 0, -1, acc);
      tick();
      checks++;
      if ({ren_v, wen_v, lif.cfg_table_r_addr} !== {3'b001, 3'b000, 8'h00}) begin
         failures++; $display("FAIL ver_first_ren ren/wen/addr got=%b exp=001/000/0", {ren_v, wen_v, lif.cfg_table_r_addr});
      end
      wait_done(n);
      checks++;
      if (n !== 3 * N + 1 || err !== 1'b0) begin
         failures++; $display("FAIL ver_clean latency=%0d err=%b exp=%0d/0", n, err, 3 * N + 1);
      end
      tick();
      checks++;
      if (ren_cnt[0] !== N || ren_cnt[1] !== N || ren_cnt[2] !== N || strobe_err !== 0) begin
         failures++; $display("FAIL ver_reads got=%0d/%0d/%0d strobe=%0d exp=256 each/0",
            ren_cnt[0], ren_cnt[1], ren_cnt[2], strobe_err);
      end
      fault = 1'b1;
      arm_load();
      drive_load(TOTAL, 0, -1, acc);
      wait_done(n);
      checks++;
      if (done !== 1'b1 || err !== 1'b1) begin
         failures++; $display("FAIL ver_fault_err done=%b err=%b exp=1/1", done, err);
      end
      repeat (5) tick();
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL ver_err_sticky err=%b busy=%b exp=1/0", err, busy);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         failures++; $display("FAIL ver_err_clear err=%b exp=0", err);
      end
      fault = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_arm_wait();
      test_full_load();
      test_throttled();
      test_boundary();
      test_midload_reset();
`ifdef GAMMA_LUT_VERIFY_EN
      test_verify();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/isp_gamma_lut_loader.md
# isp_gamma_lut_loader

Streams a complete gamma table set (R, G, B) from a host/DMA entry stream into the three gamma LUT RAMs through their configuration write ports. It is the writer-side companion of the pixel-path gamma block and drives `cfg_table_{r,g,b}_*` directly. Writes are deferred to the next frame boundary (`in_vsync` rising edge) so a table never changes mid-frame. An optional read-back pass checks the stored contents.

## Interface
- `BITS`, default 8: LUT address and data width; each table holds 2^BITS entries.
- `pclk`  in  1  pixel/config clock; all table `cfg_table_*_clk` ports are tied to `pclk` at top level.
- `rst`  in  1  **one clock; reset is asynchronous and active-high.**
- `start`  in  1  request a full table load; ignored while `busy`.
- `in_vsync`  in  1  frame sync from the pixel pipeline.
- `s_valid`  in  1  entry stream valid.
- `s_ready`  out  1  entry stream ready.
- `s_data`  in  BITS  entry value; order is R[0..N-1], G[0..N-1], B[0..N-1], with N = 2^BITS.
- `cfg_table_{r,g,b}_wen`  out  1  per-table write strobe.
- `cfg_table_{r,g,b}_ren`  out  1  per-table read strobe.
- `cfg_table_{r,g,b}_addr`  out  BITS  table address; all three share one address register.
- `cfg_table_{r,g,b}_wdata`  out  BITS  write data; all three share one data register.
- `cfg_table_{r,g,b}_rdata`  in  BITS  read data, valid one cycle after `ren`.
- `busy`  out  1  high in ARM, WRITE, VERIFY.
- `done`  out  1  one-cycle pulse at load completion.
- `err`  out  1  sticky verify mismatch; cleared when a `start` is accepted.

## Operation
- States:
  - IDLE: `start` → ARM; clears `err`, sums, channel (0 = R), and address counter.
  - ARM: wait for an `in_vsync` rising edge (`in_vsync & ~vsync_q`) → WRITE.
  - WRITE: `s_ready` = 1.
    - Each accepted beat (`s_valid & s_ready`) registers the address counter and `s_data` to `addr`/`wdata` and pulses the selected channel's `wen` on the next cycle.
    - The counter increments. At N-1 it wraps to 0 and the channel advances.
    - After B[N-1] is accepted, go to VERIFY if it is compiled in, otherwise DONE.
  - VERIFY: see Configuration.
  - DONE: `done` = 1 for one cycle → IDLE.
- A channel sum is `BITS+BITS` bits wide, unsigned, and wraps modulo 2^(2·BITS). WRITE adds every accepted beat to the current channel's sum.
- `s_valid` gaps are allowed. `wen` is simply absent during gaps, and the counter holds.
- `start` while busy: ignored, no effect.
- An edge seen on the same cycle `start` is accepted does not count; ARM needs a later edge.
- `in_vsync` activity during WRITE/VERIFY is ignored. The load is never re-synchronised.
- `rst` mid-operation: all state and outputs return to reset values immediately. Partially written table contents are left as-is, and no `done` is produced.
- `wen` and `ren` are never high on the same cycle. At most one channel strobes per cycle.

## Timing
- Reset values:
  - All `wen`, `ren`, `addr`, `wdata` = 0.
  - `s_ready`, `busy`, `done`, `err` = 0.
  - State is IDLE.
- `start` at cycle t: `busy` = 1 from t+1.
- Rising-edge detect: `in_vsync` high at cycle e (low at e-1) → state WRITE and `s_ready` = 1 from e+1.
- Beat accepted at cycle a → `wen` = 1 at a+1 with `addr`/`wdata` of that beat. Full rate is one entry per cycle, so a gap-free load takes 3N accept cycles.
- Without verify: last accept at cycle L → final `wen` at L+1, `done` = 1 and `busy` = 0 at L+1, IDLE at L+2.
- `s_ready` drops the cycle after the last accept.

## Configuration
- Macro `GAMMA_LUT_VERIFY_EN`.
- Defined: VERIFY state is compiled in.
  - Reads addresses 0..N-1 for R, then G, then B, one `ren` per cycle with no gaps. The first `ren` is on the cycle after the last `wen`.
  - Each `rdata` is summed one cycle after its `ren`.
  - At each channel end the read sum is compared with the write sum. Any mismatch sets `err`.
  - `done` pulses one cycle after the last read data is captured: 3N+2 cycles after the last `wen`. `err` is valid on the `done` cycle.
- Undefined: no VERIFY state. `ren` outputs are tied 0, `err` is tied 0, and `rdata` inputs are unused.

## Test plan
- Reset / idle: assert `rst` mid-run → every output 0 within the same cycle. After release, `start` without an `in_vsync` edge → `busy` = 1, `s_ready` = 0 indefinitely.
- Full load, BITS=8: `start`, then a vsync edge, then 768 gap-free beats with value = index & 0xFF.
  - R/G/B tables each hold identity.
  - `wen_r` pulses 256 times, then `wen_g`, then `wen_b`.
  - `done` one cycle after the last `wen_b` (no verify).
- Throttled stream: random `s_valid` gaps (50%) → identical table contents. `addr` never skips or repeats, and no `wen` during gaps.
- Boundary events:
  - `start` in the same cycle as a vsync rise → WRITE waits for the next rise.
  - `start` pulsed during WRITE → ignored, entry count still 768.
- Verify (`GAMMA_LUT_VERIFY_EN`):
  - Model RAM correct → `err` = 0 at `done`.
  - Bench forces G[17] read to 0x00 instead of 0x11 → `err` = 1 at `done`, and it stays 1 until the next `start`.
- Mid-load reset: `rst` after 300 beats → no `done`. A fresh load afterwards completes normally with correct contents.
